rle_encoder: RTL and testbench

Run-length encoder feeding the run-length decoder's pair memory. Accepts a valid/ready stream of data words, collapses consecutive equal words into (value, repeat) pairs, and writes each pair through the decoder's CS/wr_en/wr_adr/wr_din/wr_cin write port at consecutive addresses starting from 0. It provides the loading stage directly upstream of the decoder.

---
 rtl/rle_encoder.sv | 127 ++++++++++++
 tb/tb_rle_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rle_encoder.sv
// Run-length encoder: collapses a valid/ready word stream into (value, repeat-1)
// pairs written to the decoder's pair memory. Define RLE_STATS_EN for in_word_cnt.
module rle_encoder #(
  parameter int DW    = 32,
  parameter int CW    = 4,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          flush,
  output logic          in_ready,
  output logic          CS,
  output logic          wr_en,
  output logic [AW-1:0] wr_adr,
  output logic [DW-1:0] wr_din,
  output logic [CW-1:0] wr_cin,
  output logic [AW:0]   pair_cnt,
  output logic          full,
  output logic          done
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]   in_word_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CW-1:0] LEN_MAX = '1;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_t        state;
  logic [DW-1:0] run_val;
  logic [CW-1:0] run_len;
  logic [AW+1:0] need;
  logic          has_room;
  logic          accept;
  logic          close_run;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Slots needed if one more differing word arrives: committed pairs, the open run, the new run.
  assign need      = {1'b0, pair_cnt} + (AW+2)'(state == RUN) + (AW+2)'(1);
  assign has_room  = (need <= DEPTH_W);
  assign in_ready  = !RST && (state == IDLE || state == RUN) && has_room && !flush;
  assign full      = (state == RUN) && !has_room;
  assign accept    = in_valid && in_ready;
  assign close_run = (in_data != run_val) || (run_len == LEN_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      CS       <= 1'b0;
      wr_en    <= 1'b0;
      wr_adr   <= '0;
      wr_din   <= '0;
      wr_cin   <= '0;
      pair_cnt <= '0;
      done     <= 1'b0;
    end else begin
      CS    <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= in_last ? FLUSH : RUN;
          end else if (flush) begin
            state <= DONE;
          end
        end
        RUN: begin
          if (accept) begin
            if (close_run) begin
              CS       <= 1'b1;
              wr_en    <= 1'b1;
              wr_adr   <= pair_cnt[AW-1:0];
              wr_din   <= run_val;
              wr_cin   <= run_len;
              pair_cnt <= pair_cnt + 1'b1;
            end
            if (in_last) state <= FLUSH;
          end else if (flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          CS       <= 1'b1;
          wr_en    <= 1'b1;
          wr_adr   <= pair_cnt[AW-1:0];
          wr_din   <= run_val;
          wr_cin   <= run_len;
          pair_cnt <= pair_cnt + 1'b1;
          state    <= DONE;
        end
        default: done <= 1'b1;
      endcase
    end
  end

  // Open-run datapath; only ever written on an accepted word, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      if (state == RUN && !close_run) begin
        run_len <= run_len + 1'b1;
      end else begin
        run_val <= in_data;
        run_len <= '0;
      end
    end
  end

`ifdef RLE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_word_cnt <= '0;
    end else if (accept) begin
      in_word_cnt <= sat_inc(in_word_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// Directed table-driven bench for rle_encoder (DEPTH=4 instance), with hand
// sequences for flush, mid-run reset and word-count corner cases.
module tb_rle_encoder;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready, CS, wr_en, full, done;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_din;
  logic [CW-1:0] wr_cin;
  logic [AW:0]   pair_cnt;
`ifdef RLE_STATS_EN
  logic [31:0]   in_word_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rle_encoder #(.DW(DW), .CW(CW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .flush(flush), .in_ready(in_ready), .CS(CS),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_din(wr_din), .wr_cin(wr_cin),
    .pair_cnt(pair_cnt), .full(full), .done(done)
`ifdef RLE_STATS_EN
    , .in_word_cnt(in_word_cnt)
`endif
  );

  typedef struct {
    logic          first;
    logic [DW-1:0] d;
    logic          last;
    logic          wr;
    logic [AW-1:0] adr;
    logic [DW-1:0] val;
    logic [CW-1:0] cin;
    int            fcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic first, input logic [DW-1:0] d, input logic last,
                              input logic wr, input logic [AW-1:0] adr,
                              input logic [DW-1:0] val, input logic [CW-1:0] cin, input int fcnt);
    vec_t v;
    v.first = first; v.d = d; v.last = last; v.wr = wr;
    v.adr = adr; v.val = val; v.cin = cin; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_cs", 32'(CS), 0);
    chk("rst_wr_adr", 32'(wr_adr), 0);
    chk("rst_wr_din", wr_din, 0);
    chk("rst_wr_cin", 32'(wr_cin), 0);
    chk("rst_pair_cnt", 32'(pair_cnt), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    RST = 1'b0;
    #1 chk("idle_in_ready", 32'(in_ready), 1);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.d; in_last = v.last;
    #1 chk("word_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("word_wr_en", 32'(wr_en), 32'(v.wr));
    chk("word_cs", 32'(CS), 32'(v.wr));
    if (v.wr) begin
      chk("word_wr_adr", 32'(wr_adr), 32'(v.adr));
      chk("word_wr_din", wr_din, v.val);
      chk("word_wr_cin", 32'(wr_cin), 32'(v.cin));
    end
  endtask

  // Final FLUSH write lands one cycle after the last word's edge, done one cycle later.
  task automatic finish(input logic [AW-1:0] adr, input logic [DW-1:0] val,
                        input logic [CW-1:0] cin, input int cnt);
    @(posedge clk); #1;
    chk("fl_wr_en", 32'(wr_en), 1);
    chk("fl_cs", 32'(CS), 1);
    chk("fl_wr_adr", 32'(wr_adr), 32'(adr));
    chk("fl_wr_din", wr_din, val);
    chk("fl_wr_cin", 32'(wr_cin), 32'(cin));
    chk("fl_pair_cnt", 32'(pair_cnt), 32'(cnt));
    chk("fl_done_early", 32'(done), 0);
    @(posedge clk); #1;
    chk("dn_wr_en", 32'(wr_en), 0);
    chk("dn_done", 32'(done), 1);
    chk("dn_in_ready", 32'(in_ready), 0);
  endtask

  localparam logic [DW-1:0] VA = 32'hA5A5_0001, VB = 32'hB0B0_0002, VC = 32'hC3C3_0003;
  localparam logic [DW-1:0] VD = 32'hD00D_0004, VE = 32'hE00E_0005, VF = 32'hF00F_0006;
  localparam logic [DW-1:0] VG = 32'h1234_5678, VR = 32'h5555_5555;

  initial begin
    // Stream A,A,A,B(last)
    tbl.push_back(mk(1, VA, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, VA, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, VA, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, VB, 1, 1, 0, VA, 2, 2));
    // 17 x C: 16 fill the run, the 17th closes it at max length
    for (int i = 0; i < 16; i++) tbl.push_back(mk(i == 0, VC, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, VC, 1, 1, 0, VC, 15, 2));
    // Alternating D,E,D,E(last): back-to-back writes
    tbl.push_back(mk(1, VD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, VE, 0, 1, 0, VD, 0, 0));
    tbl.push_back(mk(0, VD, 0, 1, 1, VE, 0, 0));
    tbl.push_back(mk(0, VE, 1, 1, 2, VD, 0, 4));
    // Distinct words without last until capacity runs out
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(i == 0, 32'h10 + 32'(i), 0, i != 0, 2'(i - 1), 32'h10 + 32'(i - 1), 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].first) do_reset();
      apply(tbl[i]);
      if (tbl[i].last) finish(2'(tbl[i].fcnt - 1), tbl[i].d, 0, tbl[i].fcnt);
    end

    // Capacity exhausted with a run open: upstream flushes it
    chk("cap_in_ready", 32'(in_ready), 0);
    chk("cap_full", 32'(full), 1);
    chk("cap_pair_cnt", 32'(pair_cnt), 3);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("cap_flush_no_wr", 32'(wr_en), 0);
    finish(3, 32'h13, 0, 4);

    // Flush with no open run: done without any write
    do_reset();
    @(negedge clk); flush = 1'b1;
    #1 chk("idle_flush_ready", 32'(in_ready), 0);
    @(posedge clk); #1; flush = 1'b0;
    chk("idle_flush_wr", 32'(wr_en), 0);
    @(posedge clk); #1;
    chk("idle_flush_wr2", 32'(wr_en), 0);
    chk("idle_flush_done", 32'(done), 1);
    chk("idle_flush_cnt", 32'(pair_cnt), 0);

    // Reset with a run of six open: run is discarded, next frame starts at address 0
    do_reset();
    for (int i = 0; i < 6; i++) apply(mk(0, VR, 0, 0, 0, 0, 0, 0));
    do_reset();
    apply(mk(0, VF, 1, 0, 0, 0, 0, 0));
    finish(0, VF, 0, 1);

    // Ten equal words with two stall cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) @(posedge clk);
      apply(mk(0, VG, i == 9, 0, 0, 0, 0, 0));
    end
    finish(0, VG, 9, 1);
`ifdef RLE_STATS_EN
    chk("word_cnt", in_word_cnt, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
